// File: rtl/bep_pkg.sv
// Shared biphase-mark definitions for the encoder and decoder: state encoding,
// parameter defaults and bit-counter sizing.
package bep_pkg;

    localparam int HALF_BIT_CYCLES_DEF = 4;
    localparam int PREAMBLE_BITS_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        PARITY
    } bep_state_t;

    // The bit counter must index both the preamble run and the 8 data bits.
    function automatic int bit_cnt_width(input int preamble_bits);
        int max_bits;
        max_bits = (preamble_bits > 8) ? preamble_bits : 8;
        return $clog2(max_bits);
    endfunction

endpackage

// File: rtl/bep_halfbit_timer.sv
// Half-bit pacing: half_tick is high in the last cycle of every half-bit.
// Restart aligns the first tick to HALF_BIT_CYCLES cycles after the restart edge.
module bep_halfbit_timer
    import bep_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = HALF_BIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic half_tick
);

    localparam logic [7:0] RELOAD = 8'(HALF_BIT_CYCLES - 1);

    logic [7:0] cnt;

    assign half_tick = enable && (cnt == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || half_tick) begin
            cnt <= RELOAD;
        end else if (enable) begin
            cnt <= cnt - 8'd1;
        end
    end

endmodule

// File: rtl/bep_encode.sv
// Biphase-mark serial encoder: preamble of '1's, data MSB first, even parity.
// Line toggles on the accepting edge; tx_ready only in IDLE or the last PARITY cycle.
module bep_encode
    import bep_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = HALF_BIT_CYCLES_DEF,
    parameter int PREAMBLE_BITS   = PREAMBLE_BITS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       line_out,
    output logic       busy,
    output logic       tx_done
);

    localparam int               CNT_W     = bit_cnt_width(PREAMBLE_BITS);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(7);

    bep_state_t       state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             parity_bit, parity_nxt;
    logic             phase, phase_nxt;
    logic             line_nxt, done_nxt;
    logic             half_tick, bit_end, accept, start_frame, cur_bit;

    bep_halfbit_timer #(
        .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (start_frame),
        .enable   (busy),
        .half_tick(half_tick)
    );

    // phase=1 means the second half of the current bit is in progress.
    assign busy        = (state != IDLE);
    assign bit_end     = half_tick && phase;
    assign tx_ready    = (state == IDLE) || ((state == PARITY) && bit_end);
    assign accept      = tx_valid && tx_ready;
    assign start_frame = accept && (state == IDLE);

    always_comb begin
        cur_bit = 1'b0;
        case (state)
            PREAMBLE: cur_bit = 1'b1;
            DATA:     cur_bit = shreg[7];
            PARITY:   cur_bit = parity_bit;
            default:  cur_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        parity_nxt  = parity_bit;
        phase_nxt   = phase;
        line_nxt    = line_out;
        done_nxt    = 1'b0;

        if (accept) begin
            // A byte taken at the end of a parity bit chains straight into DATA.
            shreg_nxt   = tx_data;
            parity_nxt  = ^tx_data;
            bit_cnt_nxt = '0;
            phase_nxt   = 1'b0;
            line_nxt    = ~line_out;
            state_nxt   = (state == IDLE) ? PREAMBLE : DATA;
            done_nxt    = (state == PARITY);
        end else if (half_tick) begin
            if (!phase) begin
                phase_nxt = 1'b1;
                if (cur_bit) begin
                    line_nxt = ~line_out;
                end
            end else begin
                phase_nxt   = 1'b0;
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
                line_nxt    = ~line_out;
                case (state)
                    PREAMBLE: begin
                        if (bit_cnt == PRE_LAST) begin
                            state_nxt   = DATA;
                            bit_cnt_nxt = '0;
                        end
                    end
                    DATA: begin
                        shreg_nxt = {shreg[6:0], 1'b0};
                        if (bit_cnt == DATA_LAST) begin
                            state_nxt   = PARITY;
                            bit_cnt_nxt = '0;
                        end
                    end
                    PARITY: begin
                        state_nxt   = IDLE;
                        bit_cnt_nxt = '0;
                        line_nxt    = line_out;
                        done_nxt    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            phase      <= 1'b0;
            line_out   <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            parity_bit <= parity_nxt;
            phase      <= phase_nxt;
            line_out   <= line_nxt;
            tx_done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bep_encode.sv
// Bench for bep_encode: fixed vectors, chaining, abort and ignore sequences,
// then random bytes recovered through a behavioural biphase-mark decoder.
`timescale 1ns/1ps
module tb_bep_encode;

    localparam int HBC       = 2;
    localparam int PRE       = 8;
    localparam int BIT_CYC   = 2 * HBC;
    localparam int FRAME_CYC = (PRE + 9) * BIT_CYC;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, line_out, busy, tx_done;

    int errors = 0;
    int checks = 0;

    logic samp[$];
    int   done_at[$];
    int   trans_cnt, done_cnt, busy_cnt, busy_runs, cyc, first_busy, last_busy;
    logic prev_line, prev_busy, hs;

    typedef struct {
        logic [7:0] data;
        int         exp_trans;
        logic       exp_par;
    } vec_t;

    bep_encode #(
        .HALF_BIT_CYCLES(HBC),
        .PREAMBLE_BITS  (PRE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .line_out(line_out),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Transitions per frame: 2 per preamble bit, one start toggle per data/parity
    // bit, plus a mid-bit toggle for every '1' among data and parity.
    function automatic int trans_model(input logic [7:0] d, input int npre);
        return 2 * npre + 9 + $countones(d) + int'(^d);
    endfunction

    task automatic mon_clear();
        samp.delete();
        done_at.delete();
        trans_cnt  = 0;
        done_cnt   = 0;
        busy_cnt   = 0;
        busy_runs  = 0;
        cyc        = 0;
        first_busy = -1;
        last_busy  = -1;
        prev_line  = line_out;
        prev_busy  = busy;
    endtask

    // One clock: sample at the falling edge, return 1ns after the rising edge.
    task automatic step();
        @(negedge clk);
        hs = tx_valid && tx_ready;
        cyc++;
        if (line_out != prev_line) trans_cnt++;
        prev_line = line_out;
        if (busy) begin
            samp.push_back(line_out);
            busy_cnt++;
            if (!prev_busy) busy_runs++;
            if (first_busy < 0) first_busy = cyc;
            last_busy = cyc;
        end
        prev_busy = busy;
        if (tx_done) begin
            done_cnt++;
            done_at.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit hold);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        hs       = 1'b0;
        while (!hs && n < 300) begin
            step();
            n++;
        end
        check("handshake", int'(hs), 1);
        if (!hold) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
        check("idle_timeout", int'(busy), 0);
        step();
        step();
    endtask

    // Recovers bits from the sampled line: every bit must open with a toggle,
    // each half must be steady, and a bit is '1' when its halves differ.
    task automatic decode(input int off, input int npre, input logic start_lvl,
                          output logic [7:0] d, output logic p, output int good);
        logic prev, b;
        int   base;
        good = 1;
        d    = 8'h00;
        p    = 1'b0;
        if (samp.size() < off + (npre + 9) * BIT_CYC) begin
            good = 0;
            return;
        end
        for (int j = 0; j < npre + 9; j++) begin
            base = off + j * BIT_CYC;
            prev = (base == 0) ? start_lvl : samp[base-1];
            if (samp[base] == prev) good = 0;
            for (int k = 1; k < HBC; k++) begin
                if (samp[base+k] != samp[base]) good = 0;
                if (samp[base+HBC+k] != samp[base+HBC]) good = 0;
            end
            b = samp[base] ^ samp[base+HBC];
            if (j < npre) begin
                if (!b) good = 0;
            end else if (j < npre + 8) begin
                d = {d[6:0], b};
            end else begin
                p = b;
            end
        end
    endtask

    task automatic check_frame(input logic [7:0] d, input int exp_trans,
                               input logic exp_par, input logic start_lvl);
        logic [7:0] rd;
        logic       rp;
        int         good, da;
        decode(0, PRE, start_lvl, rd, rp, good);
        da = (done_at.size() > 0) ? done_at[0] : -1;
        check("waveform_ok", good, 1);
        check("decoded_data", int'(rd), int'(d));
        check("parity_bit", int'(rp), int'(exp_par));
        check("busy_cycles", busy_cnt, FRAME_CYC);
        check("busy_runs", busy_runs, 1);
        check("transitions", trans_cnt, exp_trans);
        check("final_level", int'(line_out), int'(start_lvl ^ exp_trans[0]));
        check("done_pulses", done_cnt, 1);
        check("done_position", da, last_busy + 1);
    endtask

    initial begin
        vec_t       vecs[6];
        logic       lvl;
        logic [7:0] rd, rnd;
        logic       rp;
        int         good, n, exp_t;

        vecs[0] = '{8'hA5, 29, 1'b0};
        vecs[1] = '{8'h01, 27, 1'b1};
        vecs[2] = '{8'h00, 25, 1'b0};
        vecs[3] = '{8'hFF, 33, 1'b0};
        vecs[4] = '{8'h80, 27, 1'b1};
        vecs[5] = '{8'h3C, 29, 1'b0};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        hs       = 1'b0;
        #12;
        check("reset_line", int'(line_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(tx_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_clear();
        step();
        check("ready_after_reset", int'(tx_ready), 1);

        foreach (vecs[i]) begin
            mon_clear();
            lvl = line_out;
            send(vecs[i].data, 1'b0);
            wait_idle();
            check_frame(vecs[i].data, vecs[i].exp_trans, vecs[i].exp_par, lvl);
        end

        // Abort mid-frame: line is high in busy cycle 30 when starting from level 0.
        rst = 1'b1;
        #1;
        check("pre_abort_reset_line", int'(line_out), 0);
        step();
        rst = 1'b0;
        mon_clear();
        send(8'hA5, 1'b0);
        n = 0;
        while (busy_cnt < 29 && n < 200) begin
            step();
            n++;
        end
        check("abort_line_before", int'(line_out), 1);
        rst = 1'b1;
        #1;
        check("abort_line", int'(line_out), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(tx_done), 0);
        step();
        step();
        step();
        rst = 1'b0;
        step();
        check("abort_no_done", done_cnt, 0);
        check("abort_ready", int'(tx_ready), 1);
        mon_clear();
        send(8'h5A, 1'b0);
        wait_idle();
        check_frame(8'h5A, trans_model(8'h5A, PRE), ^8'h5A, 1'b0);

        // A byte offered while the encoder is mid-frame must be ignored.
        mon_clear();
        lvl = line_out;
        send(8'h96, 1'b0);
        for (int k = 0; k < 10; k++) step();
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        step();
        check("busy_offer_ignored", int'(hs), 0);
        tx_valid = 1'b0;
        wait_idle();
        check_frame(8'h96, trans_model(8'h96, PRE), ^8'h96, lvl);

        // Back-to-back bytes: second frame has no preamble and no gap.
        mon_clear();
        lvl = line_out;
        send(8'h00, 1'b1);
        tx_data = 8'hFF;
        send(8'hFF, 1'b0);
        wait_idle();
        check("chain_busy_cycles", busy_cnt, FRAME_CYC + 9 * BIT_CYC);
        check("chain_busy_runs", busy_runs, 1);
        check("chain_done_pulses", done_cnt, 2);
        check("chain_done0_pos", (done_at.size() > 0) ? done_at[0] : -1,
              first_busy + FRAME_CYC);
        check("chain_done1_pos", (done_at.size() > 1) ? done_at[1] : -1,
              first_busy + FRAME_CYC + 9 * BIT_CYC);
        decode(0, PRE, lvl, rd, rp, good);
        check("chain_f1_ok", good, 1);
        check("chain_f1_data", int'(rd), 8'h00);
        check("chain_f1_par", int'(rp), 0);
        decode(FRAME_CYC, 0, lvl, rd, rp, good);
        check("chain_f2_ok", good, 1);
        check("chain_f2_data", int'(rd), 8'hFF);
        check("chain_f2_par", int'(rp), 0);
        exp_t = trans_model(8'h00, PRE) + trans_model(8'hFF, 0);
        check("chain_transitions", trans_cnt, exp_t);
        check("chain_final_level", int'(line_out), int'(lvl ^ exp_t[0]));

        // Random loopback.
        for (int i = 0; i < 256; i++) begin
            rnd = 8'($urandom);
            mon_clear();
            lvl = line_out;
            send(rnd, 1'b0);
            wait_idle();
            check_frame(rnd, trans_model(rnd, PRE), ^rnd, lvl);
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bep_encode.md
BEP_ENCODE -- requirements
Module: bep_encode

Interface
REQ-001 SHALL have parameter HALF_BIT_CYCLES, default 4: clock cycles per half-bit; legal range 2..255.
REQ-002 SHALL have parameter PREAMBLE_BITS, default 8: number of encoded '1' bits sent before data; legal range 1..15.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port tx_data  input  8: byte to send, sampled on handshake.
REQ-006 SHALL have port tx_valid  input  1: tx_data is valid.
REQ-007 SHALL have port tx_ready  output  1: encoder can accept a byte this cycle.
REQ-008 SHALL have port line_out  output  1: registered biphase-mark encoded serial line.
REQ-009 SHALL have port busy  output  1: a frame is in progress.
REQ-010 SHALL have port tx_done  output  1: one-cycle pulse when a frame's parity bit completes.

Function
REQ-011 SHALL accept a byte on any rising edge where tx_valid and tx_ready are both 1; tx_data is latched on that edge.
REQ-012 SHALL use biphase-mark coding: line_out toggles at the start of every bit, and toggles again at mid-bit only for a '1'; each half-bit lasts HALF_BIT_CYCLES cycles.
REQ-013 SHALL send each frame as PREAMBLE_BITS '1' bits, then tx_data MSB first, then one even-parity bit (XOR of the 8 data bits); frame length (PREAMBLE_BITS+9)*2*HALF_BIT_CYCLES cycles.
REQ-014 SHALL implement states IDLE, PREAMBLE, DATA, PARITY: IDLE->PREAMBLE on handshake; PREAMBLE->DATA after last preamble bit; DATA->PARITY after bit 0; PARITY->IDLE at end of parity bit with no handshake.
REQ-015 SHALL drive the first start-of-bit toggle of a frame on the accepting edge itself, so line_out changes in the first cycle after acceptance.
REQ-016 SHALL assert tx_ready in IDLE and during the final cycle of PARITY only; 0 at all other times.
REQ-017 SHALL, on a handshake during the final cycle of PARITY, go directly to DATA (no preamble) with the new byte's MSB starting on the next cycle, with no gap.
REQ-018 SHALL hold line_out at its last level while in IDLE (no transitions).
REQ-019 SHALL pulse tx_done for exactly one cycle, the cycle after the last parity half-bit ends, including when chaining (REQ-017).
REQ-020 SHALL assert busy in every state except IDLE.
REQ-021 SHALL ignore tx_data and tx_valid changes while tx_ready is 0.

Reset
REQ-022 SHALL, on rst asserted, asynchronously force state IDLE, line_out 0, busy 0, tx_done 0, all counters 0; tx_ready 1 from the first edge after rst deasserts.
REQ-023 SHALL, on rst mid-frame, abandon the frame without completing a bit or pulsing tx_done.

Structure
REQ-024 SHALL place the state enum and parameter defaults (HALF_BIT_CYCLES, PREAMBLE_BITS) in shared package bep_pkg, reused by the decoder.
REQ-025 SHALL use one sub-module bep_halfbit_timer: a down-counter emitting a one-cycle half_tick every HALF_BIT_CYCLES cycles, restarted on frame start.
REQ-026 SHALL keep a bit counter sized for max(PREAMBLE_BITS,8) and a shift register for the data byte in bep_encode.

Verification (HALF_BIT_CYCLES=2, PREAMBLE_BITS=8)
REQ-027 SHALL verify: reset, then send 0xA5 -> 68 busy cycles, 29 line_out transitions, parity bit 0, final level 1, one tx_done pulse.
REQ-028 SHALL verify: send 0x01 -> parity bit 1, 16+9+2=27 transitions, final line_out 1.
REQ-029 SHALL verify: 0x00 then 0xFF with tx_valid held high -> second byte accepted in last PARITY cycle, no preamble between bytes, 68+36=104 contiguous busy cycles, two tx_done pulses.
REQ-030 SHALL verify: rst asserted at cycle 30 of a frame -> line_out 0 immediately, busy 0, no tx_done, next frame starts cleanly with preamble.
REQ-031 SHALL verify: tx_valid pulsed with 0x3C while busy and tx_ready 0 -> byte ignored, current frame unchanged.
REQ-032 SHALL verify: loopback through the team's bep decoder for 256 random bytes -> every byte recovered exactly.
